// File: rtl/i2c_slave_regfile.sv
// I2C-side register file: turns the byte engine's ACK handshake into pointer loads,
// auto-incrementing writes/reads with per-register read-only protection, plus a local port.
//
// state  | meaning
// S_IDLE | waiting for the register-address byte; read bytes still step the pointer
// S_DATA | address taken; write bytes store at ptr, read bytes step the pointer
module i2c_slave_regfile #(
   parameter int                    NUM_REGS   = 4,
   parameter logic [NUM_REGS*8-1:0] RESET_VALS = 32'h0000_0605,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = 4'b0000,
   parameter bit                    AUTO_INC   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            i2c_rxdata,
   input  logic                  i2c_ack,
   input  logic                  i2c_w,
   input  logic                  i2c_r,
   input  logic                  i2c_stop,
   output logic [7:0]            i2c_txdata,
   input  logic                  loc_we,
   input  logic [7:0]            loc_addr,
   input  logic [7:0]            loc_wdata,
   output logic [7:0]            loc_rdata,
   output logic [NUM_REGS*8-1:0] regs_flat,
   output logic                  wr_pulse,
   output logic [7:0]            wr_addr,
   output logic                  collision
);

   typedef enum logic {S_IDLE, S_DATA} state_t;

   localparam logic [8:0] NREGS9   = 9'(NUM_REGS);
   localparam logic [7:0] LAST_REG = 8'(NUM_REGS - 1);

   state_t     state, state_nxt;
   logic [7:0] ptr, ptr_nxt, ptr_adv;
   logic [7:0] regs [NUM_REGS];
   logic       ack_d;
   logic       ev;
   logic       ptr_in_range;
   logic       ptr_ro;
   logic       i2c_wr_en;
   logic [7:0] tx_mux, loc_mux;

   assign ev           = i2c_ack & ~ack_d;
   assign ptr_in_range = {1'b0, ptr} < NREGS9;

   always_comb begin
      ptr_ro  = 1'b0;
      tx_mux  = 8'hFF;
      loc_mux = 8'hFF;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ptr == 8'(i)) begin
            ptr_ro = RO_MASK[i];
            tx_mux = regs[i];
         end
         if (loc_addr == 8'(i)) loc_mux = regs[i];
      end
   end

   // Out-of-range pointers park where they are so a bad address never aliases a real register.
   always_comb begin
      ptr_adv = ptr;
      if (AUTO_INC) begin
         if (ptr == LAST_REG)  ptr_adv = 8'h00;
         else if (ptr_in_range) ptr_adv = ptr + 8'h01;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      i2c_wr_en = 1'b0;
      if (i2c_stop) begin
         state_nxt = S_IDLE;
      end else if (ev) begin
         case (state)
            S_IDLE: begin
               if (i2c_w) begin
                  ptr_nxt   = i2c_rxdata;
                  state_nxt = S_DATA;
               end else if (i2c_r) begin
                  ptr_nxt = ptr_adv;
               end
            end
            S_DATA: begin
               if (i2c_w) begin
                  i2c_wr_en = ptr_in_range & ~ptr_ro;
                  ptr_nxt   = ptr_adv;
               end else if (i2c_r) begin
                  ptr_nxt = ptr_adv;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         ptr   <= 8'h00;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Local writes win over a same-cycle I2C write to the same register.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rst)                                 regs[i] <= RESET_VALS[8*i +: 8];
         else if (loc_we && loc_addr == 8'(i))    regs[i] <= loc_wdata;
         else if (i2c_wr_en && ptr == 8'(i))      regs[i] <= i2c_rxdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_d      <= 1'b0;
         wr_pulse   <= 1'b0;
         wr_addr    <= 8'h00;
         collision  <= 1'b0;
         i2c_txdata <= RESET_VALS[7:0];
         loc_rdata  <= 8'h00;
      end else begin
         ack_d      <= i2c_ack;
         wr_pulse   <= i2c_wr_en;
         if (i2c_wr_en) wr_addr <= ptr;
         collision  <= collision | (i2c_wr_en & loc_we & (loc_addr == ptr));
         i2c_txdata <= tx_mux;
         loc_rdata  <= loc_mux;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs[i];
   end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: directed scenarios then random byte traffic,
// all checked against a transaction-level model of the register file.
module tb_i2c_slave_regfile;

   localparam int          N     = 4;
   localparam logic [31:0] RVALS = 32'h0000_0605;
   localparam logic [3:0]  RO    = 4'b0001;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  i2c_rxdata;
   logic        i2c_ack, i2c_w, i2c_r, i2c_stop;
   logic [7:0]  i2c_txdata;
   logic        loc_we;
   logic [7:0]  loc_addr, loc_wdata, loc_rdata;
   logic [31:0] regs_flat;
   logic        wr_pulse;
   logic [7:0]  wr_addr;
   logic        collision;

   i2c_slave_regfile #(
      .NUM_REGS(N), .RESET_VALS(RVALS), .RO_MASK(RO), .AUTO_INC(1'b1)
   ) dut (
      .clk(clk), .rst(rst),
      .i2c_rxdata(i2c_rxdata), .i2c_ack(i2c_ack), .i2c_w(i2c_w), .i2c_r(i2c_r),
      .i2c_stop(i2c_stop), .i2c_txdata(i2c_txdata),
      .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
      .regs_flat(regs_flat), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .collision(collision)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // transaction-level model
   logic [7:0] m_reg [N];
   int         m_ptr;
   bit         m_addr_done;
   bit         m_coll;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] m_flat();
      logic [31:0] f;
      for (int i = 0; i < N; i++) f[8*i +: 8] = m_reg[i];
      return f;
   endfunction

   function automatic logic [7:0] m_tx();
      return (m_ptr < N) ? m_reg[m_ptr] : 8'hFF;
   endfunction

   function automatic void m_step();
      if (m_ptr == N - 1) m_ptr = 0;
      else if (m_ptr < N) m_ptr = m_ptr + 1;
   endfunction

   task automatic do_reset;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      for (int i = 0; i < N; i++) m_reg[i] = RVALS[8*i +: 8];
      m_ptr = 0; m_addr_done = 0; m_coll = 0;
      check("rst_regs", regs_flat, m_flat());
      check("rst_tx", i2c_txdata, RVALS[7:0]);
      check("rst_loc_rdata", loc_rdata, 8'h00);
      check("rst_wr_pulse", wr_pulse, 1'b0);
      check("rst_wr_addr", wr_addr, 8'h00);
      check("rst_collision", collision, 1'b0);
   endtask

   // One byte with ACK held for several cycles; optional local write in the ACK-rise cycle.
   task automatic send_byte(input bit w, input logic [7:0] b,
                            input bit do_loc, input logic [7:0] la, input logic [7:0] ld);
      bit         exp_pulse;
      logic [7:0] exp_addr;
      exp_pulse = 0;
      exp_addr  = 8'h00;
      i2c_w = w; i2c_r = ~w; i2c_rxdata = b; i2c_ack = 1'b1;
      if (do_loc) begin
         loc_we = 1'b1; loc_addr = la; loc_wdata = ld;
      end
      if (!m_addr_done) begin
         if (w) begin m_ptr = b; m_addr_done = 1; end
         else m_step();
      end else begin
         if (w && m_ptr < N && !RO[m_ptr]) begin
            exp_pulse = 1; exp_addr = 8'(m_ptr);
            m_reg[m_ptr] = b;
         end
         m_step();
      end
      if (do_loc && la < N) begin
         m_reg[la] = ld;
         if (exp_pulse && la == exp_addr) m_coll = 1;
      end
      tick;
      loc_we = 1'b0;
      check("wr_pulse", wr_pulse, exp_pulse);
      if (exp_pulse) check("wr_addr", wr_addr, exp_addr);
      check("regs", regs_flat, m_flat());
      check("collision", collision, m_coll);
      tick;
      check("wr_pulse_once", wr_pulse, 1'b0);
      check("txdata", i2c_txdata, m_tx());
      tick; tick;
      check("held_ack_regs", regs_flat, m_flat());
      check("held_ack_tx", i2c_txdata, m_tx());
      i2c_ack = 1'b0;
      tick;
   endtask

   task automatic wr(input logic [7:0] b);
      send_byte(1'b1, b, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic rd;
      send_byte(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic stop;
      i2c_stop = 1'b1;
      tick;
      i2c_stop = 1'b0;
      m_addr_done = 0;
   endtask

   task automatic loc_write(input logic [7:0] a, input logic [7:0] d);
      loc_we = 1'b1; loc_addr = a; loc_wdata = d;
      tick;
      loc_we = 1'b0;
      if (a < N) m_reg[a] = d;
      check("loc_write_regs", regs_flat, m_flat());
   endtask

   task automatic loc_read(input logic [7:0] a);
      loc_addr = a;
      tick;
      check("loc_rdata", loc_rdata, (a < N) ? m_reg[a] : 8'hFF);
   endtask

   initial begin
      rst = 1'b1; i2c_rxdata = 8'h00; i2c_ack = 1'b0; i2c_w = 1'b0; i2c_r = 1'b0;
      i2c_stop = 1'b0; loc_we = 1'b0; loc_addr = 8'h00; loc_wdata = 8'h00;
      tick; tick;
      do_reset;

      // multi-byte write with wrap
      wr(8'h02); wr(8'hAA); wr(8'hBB); stop;
      check("t1_ptr_wrapped", 32'(m_ptr), 32'd0);
      rd;

      // address write, repeated START, two reads
      do_reset;
      wr(8'h01); stop; rd; rd;
      check("t2_ptr", 32'(m_ptr), 32'd3);

      // read-only register, then local override
      wr(8'h00); wr(8'h77); stop;
      loc_write(8'h00, 8'h77);
      loc_read(8'h00);

      // out-of-range pointer
      wr(8'h10); wr(8'h55); stop; rd;
      loc_write(8'h20, 8'h99);
      loc_read(8'h20);

      // same-cycle local and I2C write
      wr(8'h01);
      send_byte(1'b1, 8'h22, 1'b1, 8'h01, 8'h11);
      stop;
      loc_read(8'h01);

      // reset between address and data byte
      do_reset;
      wr(8'h02);
      do_reset;
      wr(8'h03); wr(8'h99); stop;

      // random traffic
      for (int k = 0; k < 80; k++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 4)
            wr(m_addr_done ? 8'($urandom) : 8'($urandom_range(0, 5)));
         else if (sel < 6) rd;
         else if (sel == 6) stop;
         else if (sel == 7) loc_write(8'($urandom_range(0, 5)), 8'($urandom));
         else if (sel == 8) loc_read(8'($urandom_range(0, 5)));
         else if (m_addr_done)
            send_byte(1'b1, 8'($urandom), 1'b1, 8'(m_ptr), 8'($urandom));
         else
            wr(8'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised register file behind the byte-level I2C slave engine: it turns the engine's per-byte handshake into register-pointer writes, auto-incrementing multi-byte writes and reads, per-register read-only protection, and a local-side read/write port for fabric logic. It replaces the fixed 4-register address/data model at the SFP management I2C bus. It has one clock domain shared with the byte engine.

## Interface
- NUM_REGS, 4: number of 8-bit registers, 1..256.
- RESET_VALS, 32'h0000_0605: flat reset image, register i at bits [8i+7:8i]; width NUM_REGS*8.
- RO_MASK, 4'b0000: bit i = 1 makes register i read-only from I2C. The local port can still write it.
- AUTO_INC, 1: 1 = pointer increments after every data byte; 0 = pointer holds.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i2c_rxdata  in  8  byte received by the engine; valid while i2c_ack is high.
- i2c_ack  in  1  level, high during the ACK phase of each byte.
- i2c_w / i2c_r  in  1  current transfer is a write / a read (level).
- i2c_stop  in  1  one-cycle pulse on STOP or repeated START.
- i2c_txdata  out  8  byte the engine shifts out on a read.
- loc_we  in  1  local write strobe.
- loc_addr  in  8  local address.
- loc_wdata  in  8  local write data.
- loc_rdata  out  8  registered local read data.
- regs_flat  out  NUM_REGS*8  live register contents.
- wr_pulse  out  1  one cycle for every accepted I2C register write.
- wr_addr  out  8  address of that write.
- collision  out  1  sticky flag; set when a same-cycle I2C write loses to a local write. Cleared only by reset.

## Operation
- Byte event: `ev = i2c_ack & ~ack_d`, where ack_d is i2c_ack registered. Every action below is qualified by ev; one action per byte.
- State machine:
  - IDLE: on ev with i2c_w, load ptr <= i2c_rxdata and go to DATA. On ev with i2c_r, perform a read step and stay in IDLE.
  - DATA: on ev with i2c_w, perform a write step. On ev with i2c_r, perform a read step.
  - Any state: i2c_stop returns the block to IDLE. ptr is retained, so write-address then repeated-START read works. i2c_stop takes priority over ev in the same cycle.
- Write step:
  - If ptr < NUM_REGS and RO_MASK[ptr] = 0: reg[ptr] <= i2c_rxdata, and wr_pulse/wr_addr fire on the next cycle.
  - Otherwise the byte is dropped and there is no wr_pulse.
  - Then advance ptr.
- Read step: advance ptr. The byte just shifted was i2c_txdata.
- Advance ptr, only when AUTO_INC = 1:
  - ptr == NUM_REGS-1 goes to 0 (wrap).
  - ptr >= NUM_REGS holds.
  - Otherwise ptr+1.
- i2c_txdata = reg[ptr] if ptr < NUM_REGS, else 8'hFF.
- Local port:
  - loc_we with loc_addr < NUM_REGS writes that register, ignoring RO_MASK. Out-of-range local writes are ignored.
  - loc_rdata = reg[loc_addr], or 8'hFF when out of range. It is sampled every cycle.
  - If a local write and an I2C write target the same register in the same cycle, the local write wins and collision is set. ptr still advances. wr_pulse still fires, because the I2C byte was accepted by the protocol.

## Timing
- Reset (rst sampled high at a clk edge):
  - regs_flat = RESET_VALS, ptr = 0, state = IDLE.
  - i2c_txdata = RESET_VALS[7:0], loc_rdata = 0.
  - wr_pulse = 0, wr_addr = 0, collision = 0, ack_d = 0.
- Reset mid-transfer aborts the transfer. Bytes after reset release are treated as a new transaction in IDLE.
- i2c_ack rises in cycle N, so ev is true in cycle N. At the end of N, the register, ptr and state update.
  - regs_flat shows the new value in N+1.
  - wr_pulse is high in N+1 only.
  - i2c_txdata is registered and reflects the new ptr in N+2.
  - The engine must not sample txdata earlier than 2 cycles after ACK rise.
- Local write in cycle M is visible in regs_flat at M+1. loc_rdata has 1-cycle latency.
- i2c_ack held high for many cycles yields exactly one ev.

## Test plan
- Reset, then write bytes 0x02, 0xAA, 0xBB, then STOP → reg2 = 0xAA, reg3 = 0xBB, ptr = 0 (wrap), exactly two wr_pulse with wr_addr 2 then 3.
- Write address 0x01, repeated START, read two bytes → txdata 0x06 then 0x00 (after reset), ptr ends at 3.
- RO_MASK = 4'b0001: write address 0x00, data 0x77 → reg0 stays 0x05, no wr_pulse, ptr advances to 1. Then local write 0x77 to address 0 → reg0 = 0x77.
- Write address 0x10 with NUM_REGS = 4, data 0x55 → no register changes, ptr holds 0x10, read returns 0xFF.
- Local write 0x11 to reg1 in the same cycle as an I2C write of 0x22 to reg1 → reg1 = 0x11, collision = 1, wr_pulse = 1.
- Assert rst between the address byte and the data byte → regs = RESET_VALS. The following byte 0x03 is taken as an address, not as data.
